// File: rtl/des_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : des_out_serializer
// Brief    : Buffers 64-bit DES results in a small FIFO and streams each word
//            out MSB-first as OUT_WIDTH-bit beats over valid/ready.
// Revision : 1.0
// ============================================================================
module des_out_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int OUT_WIDTH  = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_beat_ready,
    input  logic                  i_clr_overflow,
    output logic [OUT_WIDTH-1:0]  o_beat,
    output logic                  o_beat_valid,
    output logic                  o_last,
    output logic [DEPTH_LOG2:0]   o_fifo_count,
    output logic                  o_overflow,
    output logic                  o_busy
);

    localparam int c_N      = DATA_WIDTH / OUT_WIDTH;
    localparam int c_DEPTH  = 1 << DEPTH_LOG2;
    localparam int c_BEAT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_N - 1);
    localparam logic [DEPTH_LOG2:0] c_FULL      = (DEPTH_LOG2 + 1)'(c_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [c_BEAT_W-1:0]     r_beat;
    logic                    r_overflow;

    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_send;
    logic w_accept;
    logic w_last_beat;
    logic w_fifo_nonempty;

    assign w_fifo_nonempty = (r_count != '0);
    assign w_last_beat     = (r_beat == c_LAST_BEAT);
    assign w_accept        = w_send & i_beat_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push          = i_valid & ((r_count != c_FULL) | w_pop);
    assign w_drop          = i_valid & ~w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_send      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                w_send = 1'b1;
                if (i_beat_ready && w_last_beat) begin
                    if (w_fifo_nonempty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_shift    <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
                r_beat  <= '0;
            end else if (w_accept && !w_last_beat) begin
                r_shift <= r_shift << OUT_WIDTH;
                r_beat  <= r_beat + 1'b1;
            end

            // Drop wins over clear so a loss in the clearing cycle is never hidden.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_beat_valid = w_send;
    assign o_beat       = w_send ? r_shift[DATA_WIDTH-1 -: OUT_WIDTH] : '0;
    assign o_last       = w_send & w_last_beat;
    assign o_fifo_count = r_count;
    assign o_overflow   = r_overflow;
    assign o_busy       = w_send | w_fifo_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_des_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_out_serializer
// Brief    : Directed self-checking bench for des_out_serializer.
// Revision : 1.0
// ============================================================================
module tb_des_out_serializer;

    logic        clk;
    logic        rst_n;
    logic [63:0] i_data;
    logic        i_valid;
    logic        i_beat_ready;
    logic        i_clr_overflow;
    logic [7:0]  o_beat;
    logic        o_beat_valid;
    logic        o_last;
    logic [2:0]  o_fifo_count;
    logic        o_overflow;
    logic        o_busy;

    int n_checks;
    int n_errors;
    logic [63:0] r_words [8];

    des_out_serializer #(
        .DATA_WIDTH (64),
        .OUT_WIDTH  (8),
        .DEPTH_LOG2 (2)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .i_beat_ready   (i_beat_ready),
        .i_clr_overflow (i_clr_overflow),
        .o_beat         (o_beat),
        .o_beat_valid   (o_beat_valid),
        .o_last         (o_last),
        .o_fifo_count   (o_fifo_count),
        .o_overflow     (o_overflow),
        .o_busy         (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks beats first..7 of word w, one per cycle, advancing a negedge after each.
    task automatic expect_beats(input logic [63:0] w, input int first, input string tag);
        for (int i = first; i < 8; i++) begin
            check($sformatf("%s_valid%0d", tag, i), {63'd0, o_beat_valid}, 64'd1);
            check($sformatf("%s_beat%0d", tag, i), {56'd0, o_beat}, {56'd0, w[63-8*i -: 8]});
            check($sformatf("%s_last%0d", tag, i), {63'd0, o_last}, (i == 7) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
    endtask

    task automatic push_six();
        i_beat_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_data  = r_words[k];
            i_valid = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        i_data         = '0;
        i_valid        = 1'b0;
        i_beat_ready   = 1'b0;
        i_clr_overflow = 1'b0;
        r_words[0] = 64'h0F1E2D3C4B5A6978;
        r_words[1] = 64'h8796A5B4C3D2E1F0;
        r_words[2] = 64'h0011223344556677;
        r_words[3] = 64'h8899AABBCCDDEEFF;
        r_words[4] = 64'hFEDCBA9876543210;
        r_words[5] = 64'hDEADBEEFDEADBEEF;
        r_words[6] = 64'hBADC0FFEE0DDF00D;
        r_words[7] = 64'h5A5A5A5AA5A5A5A5;

        repeat (2) @(negedge clk);
        check("rst_valid", {63'd0, o_beat_valid}, 64'd0);
        check("rst_count", {61'd0, o_fifo_count}, 64'd0);
        check("rst_ovf",   {63'd0, o_overflow},   64'd0);
        check("rst_busy",  {63'd0, o_busy},       64'd0);
        check("rst_beat",  {56'd0, o_beat},       64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, latency and ordering
        i_beat_ready = 1'b1;
        i_data       = 64'h0123456789ABCDEF;
        i_valid      = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        check("t1_count_after_push", {61'd0, o_fifo_count}, 64'd1);
        check("t1_valid_early",      {63'd0, o_beat_valid}, 64'd0);
        @(negedge clk);
        expect_beats(64'h0123456789ABCDEF, 0, "t1");
        check("t1_idle_valid", {63'd0, o_beat_valid}, 64'd0);
        check("t1_idle_busy",  {63'd0, o_busy},       64'd0);

        // Two words back to back with no bubble
        i_data  = 64'h1122334455667788;
        i_valid = 1'b1;
        @(negedge clk);
        i_data  = 64'h99AABBCCDDEEFF00;
        @(negedge clk);
        i_valid = 1'b0;
        expect_beats(64'h1122334455667788, 0, "t2a");
        expect_beats(64'h99AABBCCDDEEFF00, 0, "t2b");
        check("t2_idle_valid", {63'd0, o_beat_valid}, 64'd0);

        // Back-pressure mid-word
        i_data  = 64'hA1B2C3D4E5F60718;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_pre%0d", i), {56'd0, o_beat},
                  (i == 0) ? 64'hA1 : (i == 1) ? 64'hB2 : 64'hC3);
            @(negedge clk);
        end
        i_beat_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold_beat%0d", i),  {56'd0, o_beat},       64'hD4);
            check($sformatf("t3_hold_last%0d", i),  {63'd0, o_last},       64'd0);
            check($sformatf("t3_hold_valid%0d", i), {63'd0, o_beat_valid}, 64'd1);
            @(negedge clk);
        end
        i_beat_ready = 1'b1;
        expect_beats(64'hA1B2C3D4E5F60718, 3, "t3");
        check("t3_idle_valid", {63'd0, o_beat_valid}, 64'd0);

        // Overflow: one word in shifter, four in FIFO, sixth dropped
        push_six();
        check("t4_count_full", {61'd0, o_fifo_count}, 64'd4);
        check("t4_ovf_set",    {63'd0, o_overflow},   64'd1);
        check("t4_head_beat",  {56'd0, o_beat},       64'h0F);
        check("t4_busy",       {63'd0, o_busy},       64'd1);
        i_clr_overflow = 1'b1;
        @(negedge clk);
        i_clr_overflow = 1'b0;
        check("t4_ovf_clr", {63'd0, o_overflow}, 64'd0);
        i_clr_overflow = 1'b1;
        i_data         = r_words[6];
        i_valid        = 1'b1;
        @(negedge clk);
        i_clr_overflow = 1'b0;
        i_valid        = 1'b0;
        check("t4_clr_drop_ovf", {63'd0, o_overflow},   64'd1);
        check("t4_clr_drop_cnt", {61'd0, o_fifo_count}, 64'd4);
        i_clr_overflow = 1'b1;
        @(negedge clk);
        i_clr_overflow = 1'b0;
        check("t4_ovf_clr2", {63'd0, o_overflow}, 64'd0);

        // Full FIFO: push coincides with last-beat pop
        i_beat_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t5_w0_beat%0d", i), {56'd0, o_beat}, {56'd0, r_words[0][63-8*i -: 8]});
            @(negedge clk);
        end
        check("t5_w0_last", {63'd0, o_last}, 64'd1);
        i_data  = r_words[7];
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        check("t5_count",   {61'd0, o_fifo_count}, 64'd4);
        check("t5_no_ovf",  {63'd0, o_overflow},   64'd0);
        expect_beats(r_words[1], 0, "t5w1");
        expect_beats(r_words[2], 0, "t5w2");
        expect_beats(r_words[3], 0, "t5w3");
        expect_beats(r_words[4], 0, "t5w4");
        expect_beats(r_words[7], 0, "t5w7");
        check("t5_idle_valid", {63'd0, o_beat_valid}, 64'd0);
        check("t5_idle_count", {61'd0, o_fifo_count}, 64'd0);
        check("t5_idle_busy",  {63'd0, o_busy},       64'd0);

        // Asynchronous reset mid-word
        push_six();
        check("t6_pre_ovf", {63'd0, o_overflow}, 64'd1);
        i_beat_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        check("t6_beat3", {56'd0, o_beat}, {56'd0, r_words[0][39:32]});
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {63'd0, o_beat_valid}, 64'd0);
        check("t6_rst_count", {61'd0, o_fifo_count}, 64'd0);
        check("t6_rst_ovf",   {63'd0, o_overflow},   64'd0);
        check("t6_rst_beat",  {56'd0, o_beat},       64'd0);
        check("t6_rst_last",  {63'd0, o_last},       64'd0);
        check("t6_rst_busy",  {63'd0, o_busy},       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_post_valid", {63'd0, o_beat_valid}, 64'd0);
        check("t6_post_count", {61'd0, o_fifo_count}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
